// File: rtl/booth_pkg.sv
// booth_pkg: shared defaults, FSM state encoding and id-width helper for the Booth multiplier arbiter
package booth_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int N_REQ_DEF = 4;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/booth_seq_core.sv
// booth_seq_core: radix-2 Booth sequential multiplier, one iteration per clock
//   start   loads operands (a multiplicand, b multiplier) and arms WIDTH iterations
//   done    high during the final iteration; product is valid on that same cycle
//   product exact signed result of the final iteration (combinational)
module booth_seq_core import booth_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic signed [WIDTH-1:0]   a,
  input  logic signed [WIDTH-1:0]   b,
  output logic                      done,
  output logic signed [2*WIDTH-1:0] product
);
  localparam int CW = id_width(WIDTH);
  logic signed [WIDTH:0] acc, m, sum, acc_n;
  logic [WIDTH-1:0] q, q_n;
  logic q1, run;
  logic [CW-1:0] cnt;
  // The extra accumulator bit keeps acc - m exact when m = -2^(WIDTH-1).
  always_comb begin
    sum = ({q[0], q1} == 2'b10) ? acc - m : ({q[0], q1} == 2'b01) ? acc + m : acc;
    acc_n = sum >>> 1;
    q_n = {sum[0], q[WIDTH-1:1]};
    done = run && (cnt == CW'(WIDTH-1));
    product = {acc_n[WIDTH-1:0], q_n};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      m <= '0;
      q <= '0;
      q1 <= 1'b0;
      run <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      acc <= '0;
      m <= {a[WIDTH-1], a};
      q <= b;
      q1 <= 1'b0;
      run <= 1'b1;
      cnt <= '0;
    end else if (run) begin
      acc <= acc_n;
      q <= q_n;
      q1 <= q[0];
      cnt <= cnt + CW'(1);
      run <= !done;
    end
  end
endmodule

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin arbiter sharing one sequential Booth multiplier among N_REQ requesters
//   req_valid/req_ready/req_a/req_b  per-requester operand handshake, operands packed WIDTH bits each
//   rsp_valid/rsp_ready/rsp_id/rsp_product  result handshake tagged with the owning requester
//   busy  high whenever an operation is in flight or awaiting acceptance
module mul_share_arbiter import booth_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int N_REQ = N_REQ_DEF,
  localparam int IW = id_width(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*WIDTH-1:0]    req_a,
  input  logic [N_REQ*WIDTH-1:0]    req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [IW-1:0]             rsp_id,
  output logic signed [2*WIDTH-1:0] rsp_product,
  output logic                      busy
);
  state_t state, state_n;
  logic [IW-1:0] ptr, g;
  logic fire, done;
  logic signed [WIDTH-1:0] op_a, op_b;
  logic signed [2*WIDTH-1:0] product;
  // Scan from the farthest offset down so the requester nearest ptr wins.
  always_comb begin
    int idx;
    idx = 0;
    g = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (req_valid[idx]) g = IW'(idx);
    end
    fire = rst_n && (state == IDLE) && (|req_valid);
    req_ready = fire ? (N_REQ'(1) << g) : '0;
    op_a = req_a[g*WIDTH +: WIDTH];
    op_b = req_b[g*WIDTH +: WIDTH];
    state_n = (state == IDLE && (|req_valid)) ? CALC :
              (state == CALC && done)         ? DONE :
              (state == DONE && rsp_ready)    ? IDLE : state;
  end
  assign busy = state != IDLE;
  assign rsp_valid = state == DONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      rsp_id <= '0;
      rsp_product <= '0;
    end else begin
      if (state == IDLE && (|req_valid)) begin
        rsp_id <= g;
        ptr <= (g == IW'(N_REQ - 1)) ? '0 : g + IW'(1);
      end
      if (state == CALC && done) rsp_product <= product;
    end
  end
  booth_seq_core #(.WIDTH(WIDTH)) u_core (
    .clk(clk),
    .rst_n(rst_n),
    .start(fire),
    .a(op_a),
    .b(op_b),
    .done(done),
    .product(product)
  );
endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: directed scoreboard bench for mul_share_arbiter
module tb_mul_share_arbiter;
  localparam int W = 8;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic rsp_valid;
  logic rsp_ready = 1'b1;
  logic [1:0] rsp_id;
  logic [2*W-1:0] rsp_product;
  logic busy;
  typedef struct {int id; int prod;} exp_t;
  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  int opa[N];
  int opb[N];
  always #5 clk = ~clk;
  mul_share_arbiter #(.WIDTH(W), .N_REQ(N)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a(req_a),
    .req_b(req_b),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id(rsp_id),
    .rsp_product(rsp_product),
    .busy(busy)
  );
  function automatic logic [31:0] p16(input int v);
    return {16'b0, v[15:0]};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic drive(input int who);
    int a, b;
    a = opa[who];
    b = opb[who];
    req_a[who*W +: W] = a[W-1:0];
    req_b[who*W +: W] = b[W-1:0];
  endtask
  task automatic issue(input int who, input int a, input int b);
    opa[who] = a;
    opb[who] = b;
    drive(who);
    req_valid[who] = 1'b1;
  endtask
  task automatic grant(input int who, input bit keep);
    int n;
    n = 0;
    #1;
    while (req_ready == '0 && n < 40) begin
      tick();
      #1;
      n++;
    end
    chk($sformatf("grant%0d", who), 32'(req_ready), 32'(1) << who);
    sb.push_back('{who, opa[who] * opb[who]});
    tick();
    if (!keep) req_valid[who] = 1'b0;
  endtask
  task automatic wait_rsp();
    int n;
    n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
    chk("rsp_valid_rise", 32'(rsp_valid), 32'(1));
  endtask
  always @(negedge clk) begin
    #1;
    if (rst_n && rsp_valid && rsp_ready) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'(1));
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_product", 32'(rsp_product), p16(e.prod));
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bit seen;
    req_valid = '1;
    tick();
    tick();
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_rsp_id", 32'(rsp_id), 32'(0));
    chk("rst_rsp_product", 32'(rsp_product), 32'(0));
    req_valid = '0;
    rst_n = 1'b1;
    tick();
    issue(0, 10, 5);
    grant(0, 1'b0);
    chk("lat_busy", 32'(busy), 32'(1));
    chk("lat_e0", 32'(rsp_valid), 32'(0));
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("lat_e%0d", i), 32'(rsp_valid), 32'(0));
    end
    tick();
    chk("lat_e8", 32'(rsp_valid), 32'(1));
    chk("lat_prod", 32'(rsp_product), p16(50));
    tick();
    chk("busy_after", 32'(busy), 32'(0));
    issue(1, -128, -128);
    grant(1, 1'b0);
    wait_rsp();
    tick();
    issue(1, -25, 25);
    grant(1, 1'b0);
    rsp_ready = 1'b0;
    tick();
    rsp_ready = 1'b1;
    wait_rsp();
    tick();
    issue(1, -15, -16);
    grant(1, 1'b0);
    wait_rsp();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    issue(0, 0, 77);
    issue(2, -7, 9);
    grant(0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      chk("rdy2_held_low", 32'(req_ready), 32'(0));
      tick();
    end
    grant(2, 1'b0);
    wait_rsp();
    tick();
    rsp_ready = 1'b0;
    issue(3, 14, 14);
    grant(3, 1'b0);
    wait_rsp();
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 32'(rsp_valid), 32'(1));
      chk("hold_prod", 32'(rsp_product), p16(196));
      chk("hold_id", 32'(rsp_id), 32'(3));
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("valid_drop", 32'(rsp_valid), 32'(0));
    issue(1, 33, -3);
    grant(1, 1'b0);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    sb.delete();
    issue(1, 100, 2);
    tick();
    chk("abort_valid", 32'(rsp_valid), 32'(0));
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_ready", 32'(req_ready), 32'(0));
    chk("abort_prod", 32'(rsp_product), 32'(0));
    req_valid = '0;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      seen |= rsp_valid;
    end
    chk("abort_no_rsp", 32'(seen), 32'(0));
    issue(1, -100, 3);
    grant(1, 1'b0);
    wait_rsp();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int w = 0; w < N; w++) issue(w, 13 - 9 * w, 2 - 5 * w);
    for (int k = 0; k < 5; k++) begin
      int who;
      who = k % N;
      grant(who, 1'b1);
      opa[who] = opa[who] + 17;
      opb[who] = opb[who] - 3;
      drive(who);
      if (k == 4) req_valid = '0;
    end
    wait_rsp();
    tick();
    for (int n = 0; n < 40 && sb.size() != 0; n++) tick();
    chk("sb_drained", 32'(sb.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mul_share_arbiter.md
MUL_SHARE_ARBITER -- requirements
Module: mul_share_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  WIDTH, 8, signed operand width
  N_REQ, 4, number of requesters
REQ-002 The design SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-003 Ports SHALL be, one per line: name, direction, width, meaning.
  clk, in, 1, rising-edge clock
  rst_n, in, 1, async active-low reset
  req_valid, in, N_REQ, per-requester operand valid
  req_ready, out, N_REQ, per-requester accept
  req_a, in, N_REQ*WIDTH, packed signed multiplicands; requester i at [i*WIDTH +: WIDTH]
  req_b, in, N_REQ*WIDTH, packed signed multipliers, same packing as req_a
  rsp_valid, out, 1, result valid
  rsp_ready, in, 1, result accepted
  rsp_id, out, clog2(N_REQ), index of the requester that owns the result
  rsp_product, out, 2*WIDTH, signed product
  busy, out, 1, high in every state except IDLE

Function
REQ-004 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-005 In IDLE, when any req_valid bit is high, the block SHALL grant exactly one requester.
  - Grant is round-robin.
  - Search starts at ptr and increments with wrap-around.
REQ-006 req_ready SHALL be combinational.
  - Only bit g is high, where g is the granted index.
  - High only while in IDLE; all bits low in CALC and DONE.
REQ-007 A transfer SHALL occur on the edge where req_valid[g] and req_ready[g] are both high. On that edge:
  - capture the operands;
  - set rsp_id to g;
  - set ptr to g+1 mod N_REQ;
  - go to CALC.
REQ-008 Requesters SHALL hold req_valid and their operands stable until their transfer; ungranted requests stay pending.
REQ-009 CALC SHALL run exactly WIDTH radix-2 Booth iterations, one per edge.
  - The counter runs 0 .. WIDTH-1.
  - The next state is DONE after iteration WIDTH-1.
REQ-010 Booth arithmetic SHALL use a WIDTH+1-bit sign-extended multiplicand and accumulator, with arithmetic right shift of {acc, Q, q-1}.
  - (Q,q-1) = 10: subtract the multiplicand from acc.
  - (Q,q-1) = 01: add the multiplicand to acc.
  - Other values: no add or subtract.
REQ-011 rsp_product SHALL be the exact signed product for every operand pair, including -2^(WIDTH-1) * -2^(WIDTH-1).
REQ-012 Latency: with the transfer on edge E0, rsp_valid SHALL rise after edge E0+WIDTH (E8 for WIDTH=8).
REQ-013 In DONE, rsp_valid SHALL be high, with rsp_product and rsp_id held stable until rsp_valid and rsp_ready are both high on an edge.
  - The FSM then returns to IDLE.
  - No new grant is made in DONE.
REQ-014 rsp_ready high or low during IDLE or CALC SHALL have no effect.
REQ-015 Minimum spacing between successive transfers SHALL be WIDTH+2 cycles.
REQ-016 When requests arrive simultaneously, grants SHALL follow round-robin order from ptr; no requester waits more than N_REQ-1 other grants.

Reset
REQ-017 When rst_n is low, the block SHALL immediately force:
  - state to IDLE;
  - ptr, the counter, rsp_id and rsp_product to 0;
  - rsp_valid, busy and req_ready to 0.
REQ-018 Reset asserted during CALC or DONE SHALL discard the operation in flight with no rsp_valid pulse.
  - After reset, the first grant uses ptr=0.

Structure
REQ-019 Package booth_pkg SHALL hold:
  - the default WIDTH and N_REQ;
  - the FSM state enum (IDLE, CALC, DONE);
  - a function computing the rsp_id width.
REQ-020 The Booth datapath (acc, Q, q-1, iteration counter) SHALL be sub-module booth_seq_core.
  - Ports: start, operands, done, product.
  - mul_share_arbiter holds the FSM, the round-robin pointer, the handshakes and the response register.

Verification
REQ-021 The bench SHALL cover these directed scenarios (WIDTH=8, N_REQ=4):
  - req0 drives 10 and 5 with rsp_ready=1 -> after 8 calc edges, rsp_product=50 and rsp_id=0; busy low on the following cycle.
  - req1 drives -128 and -128 -> 16384; req1 drives -25 and 25 -> -625; req1 drives -15 and -16 -> 240.
  - From reset, req0 and req2 assert together -> req0 granted first and receives 0; req2 granted second and receives its product; req_ready[2] stays low until DONE completes.
  - req3 drives 14 and 14, and rsp_ready is held low for 5 cycles after rsp_valid -> 196 and rsp_id=3 stay stable; rsp_valid drops one edge after rsp_ready rises.
  - rst_n pulses low at the 4th CALC cycle -> no rsp_valid appears; the next request from req1 yields the correct product.
  - All four requesters hold valid continuously -> grant order 0,1,2,3,0; each request is served exactly once per round.
